// File: rtl/mac_pkg.sv
// Shared types for the pipelined multiply-accumulate block.
package mac_pkg;

  typedef struct packed {
    logic valid;
    logic mode;
    logic last;
  } beat_side_t;

endpackage

// File: rtl/mac_pipe_mult.sv
// Enable-gated unsigned multiplier pipeline; only the valid bits are reset.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2,
  localparam int PROD_W     = 2*WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  beat_side_t        side_in,
  output logic [PROD_W-1:0] prod,
  output beat_side_t        side_out
);

  logic [PIPE_STAGES-1:0]             vld_pipe;
  logic [PIPE_STAGES-1:0]             mode_q;
  logic [PIPE_STAGES-1:0]             last_q;
  logic [PIPE_STAGES-1:0][PROD_W-1:0] prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= side_in.valid;
      for (int i = 1; i < PIPE_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Bubbles carry stale data; the valid bit alone qualifies each stage.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_q[0] <= PROD_W'(a) * PROD_W'(b);
      mode_q[0] <= side_in.mode;
      last_q[0] <= side_in.last;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        mode_q[i] <= mode_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign prod           = prod_q[PIPE_STAGES-1];
  assign side_out.valid = vld_pipe[PIPE_STAGES-1];
  assign side_out.mode  = mode_q[PIPE_STAGES-1];
  assign side_out.last  = last_q[PIPE_STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined unsigned multiply / multiply-accumulate with valid/ready on both sides.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] c_out,
  output logic                 acc_ovf
);

  localparam int PROD_W = 2*WIDTH;

  if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc
    $error("mac_pipe: ACC_WIDTH must be at least 2*WIDTH");
  end
  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("mac_pipe: PIPE_STAGES must be at least 1");
  end

  // Whole pipeline moves in lockstep; a held result freezes every stage.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  logic [WIDTH-1:0] s0_a, s0_b;
  logic             s0_vld, s0_mode, s0_last;
  beat_side_t       s0_side;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     s0_vld <= 1'b0;
    else if (en) s0_vld <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s0_a    <= a_in;
      s0_b    <= b_in;
      s0_mode <= mode;
      s0_last <= in_last;
    end
  end

  assign s0_side.valid = s0_vld;
  assign s0_side.mode  = s0_mode;
  assign s0_side.last  = s0_last;

  logic [PROD_W-1:0] m_prod;
  beat_side_t        m_side;

  mult_pipe #(
    .WIDTH       (WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (s0_a),
    .b        (s0_b),
    .side_in  (s0_side),
    .prod     (m_prod),
    .side_out (m_side)
  );

  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf_trk;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;

  assign sum   = {1'b0, acc} + (ACC_WIDTH+1)'(m_prod);
  assign carry = sum[ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c_out     <= '0;
      acc_ovf   <= 1'b0;
      acc       <= '0;
      ovf_trk   <= 1'b0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (m_side.valid) begin
        if (!m_side.mode) begin
          // Product beats bypass the accumulator so they can sit inside a packet.
          c_out     <= ACC_WIDTH'(m_prod);
          acc_ovf   <= 1'b0;
          out_valid <= 1'b1;
        end else if (!m_side.last) begin
          acc     <= sum[ACC_WIDTH-1:0];
          ovf_trk <= ovf_trk | carry;
        end else begin
          c_out     <= sum[ACC_WIDTH-1:0];
          acc_ovf   <= ovf_trk | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_trk   <= 1'b0;
        end
      end
    end
  end

endmodule
